// File: rtl/rsa_core_if.sv
// Operand/result bundle for rsa_core. The core_err signal exists only when
// RSA_CORE_ERR_EN is defined.
interface rsa_core_if;
    logic       core_start;
    logic [7:0] core_m;
    logic [7:0] core_e;
    logic [7:0] core_n;
    logic       core_rdy;
    logic [7:0] core_c;
`ifdef RSA_CORE_ERR_EN
    logic       core_err;

    modport master (output core_start, core_m, core_e, core_n,
                    input  core_rdy, core_c, core_err);
    modport slave  (input  core_start, core_m, core_e, core_n,
                    output core_rdy, core_c, core_err);
`else
    modport master (output core_start, core_m, core_e, core_n,
                    input  core_rdy, core_c);
    modport slave  (input  core_start, core_m, core_e, core_n,
                    output core_rdy, core_c);
`endif
endinterface

// File: rtl/rsa_core.sv
// 8-bit modular exponentiation m^e mod n, fixed 64-cycle right-to-left square-and-multiply.
// Optional operand check and core_err output are enabled by macro RSA_CORE_ERR_EN.
module rsa_core #(
    parameter bit CLK_EDGE = 1'b1
) (
    input  logic     core_clk,
    input  logic     core_rst,
    rsa_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXP, DONE} state_e;

    state_e     state_q, state_d;
    logic [7:0] e_q, e_d;
    logic [7:0] n_q, n_d;
    logic [7:0] base_q, base_d;
    logic [7:0] result_q, result_d;
    logic [7:0] pAcc_q, pAcc_d;
    logic [7:0] sAcc_q, sAcc_d;
    logic [7:0] c_q, c_d;
    logic [5:0] cyc_q, cyc_d;
    logic       rdy_q, rdy_d;
    logic [2:0] bitIdx;
    logic [7:0] pNext, sNext;
    logic       activeClk;
`ifdef RSA_CORE_ERR_EN
    logic       err_q, err_d;
    logic       bad_q, bad_d;
    logic       badOps;
`endif

    // One step of the bit-serial interleaved multiplier: r = 2r + b*a, then two conditional subtracts.
    function automatic logic [7:0] modStep(input logic [7:0] r, input logic [7:0] a,
                                           input logic b, input logic [7:0] n);
        logic [9:0] acc;
        acc = {1'b0, r, 1'b0} + (b ? {2'b00, a} : 10'd0);
        if (acc >= {2'b00, n}) acc = acc - {2'b00, n};
        if (acc >= {2'b00, n}) acc = acc - {2'b00, n};
        return acc[7:0];
    endfunction

    assign activeClk = CLK_EDGE ? core_clk : ~core_clk;
    assign bitIdx    = 3'd7 - cyc_q[2:0];
    assign pNext     = modStep(pAcc_q, result_q, base_q[bitIdx], n_q);
    assign sNext     = modStep(sAcc_q, base_q, base_q[bitIdx], n_q);
`ifdef RSA_CORE_ERR_EN
    assign badOps    = (bus.core_n < 8'd2) || (bus.core_m >= bus.core_n);
`endif

    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        n_d      = n_q;
        base_d   = base_q;
        result_d = result_q;
        pAcc_d   = pAcc_q;
        sAcc_d   = sAcc_q;
        c_d      = c_q;
        cyc_d    = cyc_q;
        rdy_d    = rdy_q;
`ifdef RSA_CORE_ERR_EN
        err_d    = err_q;
        bad_d    = bad_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.core_start) begin
                    e_d      = bus.core_e;
                    n_d      = bus.core_n;
                    base_d   = bus.core_m;
                    result_d = 8'd1;
                    pAcc_d   = 8'd0;
                    sAcc_d   = 8'd0;
                    cyc_d    = 6'd0;
                    rdy_d    = 1'b0;
                    state_d  = EXP;
`ifdef RSA_CORE_ERR_EN
                    err_d    = 1'b0;
                    bad_d    = badOps;
`endif
                end
            end
            EXP: begin
                pAcc_d = pNext;
                sAcc_d = sNext;
                cyc_d  = cyc_q + 6'd1;
                // Bit slot boundary: commit square and (conditionally) product, restart accumulators.
                if (cyc_q[2:0] == 3'd7) begin
                    pAcc_d = 8'd0;
                    sAcc_d = 8'd0;
                    base_d = sNext;
                    if (e_q[cyc_q[5:3]]) result_d = pNext;
                end
                if (cyc_q == 6'd63) begin
                    c_d     = e_q[7] ? pNext : result_q;
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
`ifdef RSA_CORE_ERR_EN
                if (bad_q) begin
                    c_d     = 8'h00;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge activeClk or negedge core_rst) begin
        if (!core_rst) begin
            state_q  <= IDLE;
            e_q      <= 8'd0;
            n_q      <= 8'd0;
            base_q   <= 8'd0;
            result_q <= 8'd0;
            pAcc_q   <= 8'd0;
            sAcc_q   <= 8'd0;
            c_q      <= 8'd0;
            cyc_q    <= 6'd0;
            rdy_q    <= 1'b0;
`ifdef RSA_CORE_ERR_EN
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            n_q      <= n_d;
            base_q   <= base_d;
            result_q <= result_d;
            pAcc_q   <= pAcc_d;
            sAcc_q   <= sAcc_d;
            c_q      <= c_d;
            cyc_q    <= cyc_d;
            rdy_q    <= rdy_d;
`ifdef RSA_CORE_ERR_EN
            err_q    <= err_d;
            bad_q    <= bad_d;
`endif
        end
    end

    assign bus.core_rdy = rdy_q;
    assign bus.core_c   = c_q;
`ifdef RSA_CORE_ERR_EN
    assign bus.core_err = err_q;
`endif
endmodule

// File: tb/tb_rsa_core.sv
// Scoreboard bench for rsa_core: stimulus pushes expected results, a monitor pops
// and compares on every rising core_rdy. Define RSA_CORE_ERR_EN to also cover core_err.
module tb_rsa_core;
    typedef struct {
        logic [7:0] c;
        logic       err;
        int         edgeNo;
    } expItem_t;

    logic     clk;
    logic     rstN;
    int       cycCnt;
    int       checks;
    int       errors;
    logic     prevRdy;
    expItem_t expQ[$];

    rsa_core_if bus();

    rsa_core #(.CLK_EDGE(1'b1)) dut (
        .core_clk (clk),
        .core_rst (rstN),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycCnt <= cycCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Caller must be at a negedge; returns at the following negedge with start low.
    task automatic applyStimulus(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n,
                                 input logic [7:0] expC, input logic expErr, input int lat,
                                 input bit isStart, input bit doPush);
        expItem_t item;
        bus.core_m     = m;
        bus.core_e     = e;
        bus.core_n     = n;
        bus.core_start = 1'b1;
        @(posedge clk);
        #1;
        if (isStart) begin
            checkOutput("rdyDropAtStart", int'(bus.core_rdy), 0);
`ifdef RSA_CORE_ERR_EN
            checkOutput("errDropAtStart", int'(bus.core_err), 0);
`endif
        end
        if (doPush) begin
            item.c      = expC;
            item.err    = expErr;
            item.edgeNo = cycCnt + lat;
            expQ.push_back(item);
        end
        @(negedge clk);
        bus.core_start = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (expQ.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        checkOutput("drainTimeout", expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        expItem_t item;
        if (!rstN) begin
            prevRdy = 1'b0;
        end else begin
            if (bus.core_rdy && !prevRdy) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResult: got c=%0d at edge %0d, required no result",
                             bus.core_c, cycCnt);
                end else begin
                    item = expQ.pop_front();
                    checkOutput("resultC", int'(bus.core_c), int'(item.c));
                    checkOutput("resultEdge", cycCnt, item.edgeNo);
`ifdef RSA_CORE_ERR_EN
                    checkOutput("resultErr", int'(bus.core_err), int'(item.err));
`endif
                end
            end
            prevRdy = bus.core_rdy;
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        cycCnt         = 0;
        prevRdy        = 1'b0;
        rstN           = 1'b0;
        bus.core_start = 1'b0;
        bus.core_m     = 8'd0;
        bus.core_e     = 8'd0;
        bus.core_n     = 8'd0;
        #1;
        checkOutput("resetRdy", int'(bus.core_rdy), 0);
        checkOutput("resetC", int'(bus.core_c), 0);
`ifdef RSA_CORE_ERR_EN
        checkOutput("resetErr", int'(bus.core_err), 0);
`endif
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Textbook pair with n = 11*13: encrypt then decrypt.
        applyStimulus(8'd9, 8'd7, 8'd143, 8'd48, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        repeat (10) @(negedge clk);
        checkOutput("holdRdy", int'(bus.core_rdy), 1);
        checkOutput("holdC", int'(bus.core_c), 48);

        applyStimulus(8'd48, 8'd103, 8'd143, 8'd9, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd2, 8'd0, 8'd251, 8'd1, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd0, 8'd5, 8'd251, 8'd0, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd3, 8'd4, 8'd7, 8'd4, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd2, 8'd10, 8'd251, 8'd20, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd254, 8'd2, 8'd255, 8'd1, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd2, 8'd255, 8'd255, 8'd128, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd7, 8'd1, 8'd13, 8'd7, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();

        // A second start at k+10 with new operands must be ignored.
        applyStimulus(8'd9, 8'd7, 8'd143, 8'd48, 1'b0, 64, 1'b1, 1'b1);
        repeat (9) @(negedge clk);
        applyStimulus(8'd48, 8'd103, 8'd143, 8'd0, 1'b0, 0, 1'b0, 1'b0);
        waitDrain();
        repeat (20) @(negedge clk);

        // Reset at k+30 aborts the operation; nothing may appear afterwards.
        applyStimulus(8'd48, 8'd103, 8'd143, 8'd0, 1'b0, 0, 1'b1, 1'b0);
        repeat (29) @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncResetRdy", int'(bus.core_rdy), 0);
        checkOutput("asyncResetC", int'(bus.core_c), 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (80) @(negedge clk);
        checkOutput("noResultAfterAbort", int'(bus.core_rdy), 0);

`ifdef RSA_CORE_ERR_EN
        applyStimulus(8'd200, 8'd3, 8'd100, 8'd0, 1'b1, 1, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd0, 8'd3, 8'd1, 8'd0, 1'b1, 1, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'd9, 8'd7, 8'd143, 8'd48, 1'b0, 64, 1'b1, 1'b1);
        waitDrain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
